sw_array_ctrl: RTL
==================

SW_ARRAY_CTRL -- requirements
Module: sw_array_ctrl

Interface
REQ-001 SHALL take parameter PE_NUM, default 64: number of PEs in the downstream systolic array.
REQ-002 SHALL take parameter SCORE_W, default 16: score/datapath width.
REQ-003 SHALL take parameter TLEN_W, default 16: target-length counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cfg_start  in  1  one-cycle job start request.
REQ-007 cfg_q_len  in  7  query length; legal range 1..PE_NUM.
REQ-008 cfg_t_len  in  TLEN_W  target length; legal range >=1.
REQ-009 q_valid / q_ready / q_char  in / out / in  1 / 1 / 2  query character stream (A=0, C=1, G=2, T=3).
REQ-010 t_valid / t_ready / t_char  in / out / in  1 / 1 / 2  target character stream.
REQ-011 arr_rst  out  1  active-high synchronous clear to the array.
REQ-012 arr_S_load / arr_S_valid / arr_S  out  1 / 1 / 2  query shift-in controls.
REQ-013 arr_ripple_en / arr_T  out  1 / 2  target wavefront enable and character.
REQ-014 arr_max_in / arr_V_in / arr_V_alpha / arr_F_in  out  SCORE_W each  boundary values, constant 0.
REQ-015 arr_max_out  in  SCORE_W  running maximum from the last PE.
REQ-016 busy  out  1  high outside IDLE.
REQ-017 res_valid / res_ready / res_score / res_err  out / in / out / out  1 / 1 / SCORE_W / 1  result handshake.
REQ-018 cfg_err  out  1  one-cycle pulse on a rejected start.

Function
REQ-019 FSM states SHALL be IDLE, CLR, LOAD_Q, PAD_Q, STREAM, DRAIN, RESULT.
REQ-020 IDLE->CLR SHALL occur on cfg_start with legal lengths; the FSM SHALL latch both lengths, clear err, and leave res_valid at 0.
REQ-021 cfg_start with an illegal length (q_len 0 or >PE_NUM, or t_len 0) SHALL pulse cfg_err the next cycle and SHALL leave the FSM in IDLE.
REQ-022 cfg_start outside IDLE SHALL be ignored; cfg_err SHALL stay 0.
REQ-023 CLR SHALL last exactly 1 cycle with arr_rst=1; every other state SHALL drive arr_rst=0.
REQ-024 LOAD_Q: q_ready=1; each q_valid&q_ready beat SHALL drive arr_S_load=1, arr_S_valid=1, arr_S=q_char combinationally.
REQ-025 LOAD_Q: gaps in q_valid SHALL drive arr_S_load=0, and the array SHALL hold its contents.
REQ-026 LOAD_Q SHALL exit to PAD_Q after q_len accepted beats.
REQ-027 PAD_Q SHALL last PE_NUM-q_len cycles with arr_S_load=1, arr_S_valid=0, arr_S=0.
REQ-028 q_len=PE_NUM SHALL skip PAD_Q directly to STREAM.
REQ-029 After load, the first query character SHALL sit in PE0 and invalid PEs SHALL occupy the top indices.
REQ-030 STREAM: t_ready=1; arr_ripple_en=t_valid, arr_T=t_valid ? t_char : 0.
REQ-031 STREAM SHALL count accepted beats and SHALL exit to DRAIN after t_len beats.
REQ-032 STREAM: any cycle with t_valid=0 SHALL set a sticky err flag; the wavefront cannot stall, and the job SHALL still complete.
REQ-033 DRAIN SHALL last PE_NUM+2 cycles with ripple_en=0, then capture arr_max_out into res_score and err into res_err.
REQ-034 RESULT: res_valid=1 and res_score/res_err SHALL be held stable until res_valid&res_ready, then the FSM SHALL return to IDLE.
REQ-035 q_ready=0 outside LOAD_Q and t_ready=0 outside STREAM.
REQ-036 All array-side outputs SHALL be 0 in IDLE, RESULT and CLR, except arr_rst during CLR.
REQ-037 res_score SHALL be taken unmodified from arr_max_out with no saturation; the array bounds scores below 2^SCORE_W.
REQ-038 Counters SHALL be sized to never wrap: the query counter 7 bits, the stream and drain counter TLEN_W bits.

Reset
REQ-039 On rst=0, FSM SHALL go to IDLE asynchronously and all counters and flags SHALL clear to 0.
REQ-040 On rst=0, every output SHALL read 0: busy, res_valid, res_score, res_err, cfg_err, q_ready, t_ready and all arr_* outputs.
REQ-041 Reset mid-job SHALL abandon the job with no result; the next job's CLR state SHALL purge residual array state.

Structure
REQ-042 Shared package sw_pkg SHALL hold the FSM state encoding, character codes A/C/G/T, and PE_NUM/SCORE_W defaults.
REQ-043 One sub-module, sw_len_cnt, SHALL be a loadable down-counter with a zero flag, reused for the LOAD_Q, PAD_Q, STREAM and DRAIN phases.
REQ-044 All array-side outputs SHALL be combinational from the state and handshake inputs; all other outputs SHALL be registered.

Verification
REQ-045 Match job: q="ACGT", t="ACGT", continuous valid -> res_score=24, res_err=0, res_valid exactly PE_NUM+2 cycles after the last t beat plus 1 cycle.
REQ-046 Mismatch job: q="A", t="CCCC" -> res_score=0; PAD_Q asserted for exactly 63 cycles.
REQ-047 Backpressure: res_ready=0 for 10 cycles, then a second job q="GG", t="GG" -> first result held stable throughout, second res_score=12 (no carry-over of the first max).
REQ-048 Illegal start: cfg_q_len=0 or 65, or cfg_t_len=0 -> cfg_err pulse, busy stays 0; cfg_start while busy -> ignored.
REQ-049 Target gap: t_valid low 1 cycle mid-STREAM -> res_err=1 and the job still completes.
REQ-050 Reset during STREAM -> all outputs 0 immediately, IDLE; a following legal job yields the correct score.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: shared FSM encoding, character codes and array defaults for the
// Smith-Waterman array controller.
package sw_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD_Q, S_PAD_Q, S_STREAM, S_DRAIN, S_RESULT
    } state_t;
    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_C = 2'd1;
    localparam logic [1:0] CH_G = 2'd2;
    localparam logic [1:0] CH_T = 2'd3;
    localparam int PE_NUM_DEF  = 64;
    localparam int SCORE_W_DEF = 16;
endpackage

// File: rtl/sw_len_cnt.sv
// sw_len_cnt: loadable down-counter with zero flag; loaded with (length - 1)
// so the zero flag marks the final beat of a phase.
module sw_len_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: sequences a systolic Smith-Waterman array through clear, query
// load/pad, target streaming and drain, then returns the captured max score.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int PE_NUM  = PE_NUM_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int TLEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [6:0]         cfg_q_len,
    input  logic [TLEN_W-1:0]  cfg_t_len,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [1:0]         q_char,
    input  logic               t_valid,
    output logic               t_ready,
    input  logic [1:0]         t_char,
    output logic               arr_rst,
    output logic               arr_S_load,
    output logic               arr_S_valid,
    output logic [1:0]         arr_S,
    output logic               arr_ripple_en,
    output logic [1:0]         arr_T,
    output logic [SCORE_W-1:0] arr_max_in,
    output logic [SCORE_W-1:0] arr_V_in,
    output logic [SCORE_W-1:0] arr_V_alpha,
    output logic [SCORE_W-1:0] arr_F_in,
    input  logic [SCORE_W-1:0] arr_max_out,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SCORE_W-1:0] res_score,
    output logic               res_err,
    output logic               cfg_err
);
    localparam logic [6:0]        PE_Q     = 7'(PE_NUM);
    localparam logic [TLEN_W-1:0] DRAIN_M1 = TLEN_W'(PE_NUM + 1);

    state_t              r_state, w_next;
    logic [6:0]          r_q_len;
    logic [TLEN_W-1:0]   r_t_len;
    logic                r_busy, r_q_ready, r_t_ready, r_res_valid, r_res_err, r_cfg_err, r_err;
    logic [SCORE_W-1:0]  r_res_score;
    logic                w_start_ok, w_q_beat, w_t_beat, w_q_zero, w_t_zero;

    assign w_start_ok = cfg_start && cfg_q_len != 7'd0 && cfg_q_len <= PE_Q && cfg_t_len != '0;
    assign w_q_beat   = r_state == S_LOAD_Q && q_valid;
    assign w_t_beat   = r_state == S_STREAM && t_valid;

    // query counter covers LOAD_Q then PAD_Q; target counter covers STREAM then DRAIN
    sw_len_cnt #(.W(7)) u_q_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == S_CLR || (w_q_beat && w_q_zero)),
        .i_val  (r_state == S_CLR ? r_q_len - 7'd1 : PE_Q - r_q_len - 7'd1),
        .i_dec  (w_q_beat || r_state == S_PAD_Q),
        .o_zero (w_q_zero)
    );

    sw_len_cnt #(.W(TLEN_W)) u_t_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == S_CLR || (w_t_beat && w_t_zero)),
        .i_val  (r_state == S_CLR ? r_t_len - TLEN_W'(1) : DRAIN_M1),
        .i_dec  (w_t_beat || r_state == S_DRAIN),
        .o_zero (w_t_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_q_ready   <= 1'b0;
            r_t_ready   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_score <= '0;
            r_res_err   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_err       <= 1'b0;
            r_q_len     <= '0;
            r_t_len     <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= w_next != S_IDLE;
            r_q_ready   <= w_next == S_LOAD_Q;
            r_t_ready   <= w_next == S_STREAM;
            r_res_valid <= w_next == S_RESULT;
            r_cfg_err   <= r_state == S_IDLE && cfg_start && !w_start_ok;
            if (r_state == S_IDLE && w_start_ok) begin
                r_q_len <= cfg_q_len;
                r_t_len <= cfg_t_len;
                r_err   <= 1'b0;
            end else if (r_state == S_STREAM && !t_valid) begin
                r_err   <= 1'b1;
            end
            if (r_state == S_DRAIN && w_t_zero) begin
                r_res_score <= arr_max_out;
                r_res_err   <= r_err;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_CLR;
            S_CLR:    w_next = S_LOAD_Q;
            S_LOAD_Q: if (w_q_beat && w_q_zero) w_next = (r_q_len == PE_Q) ? S_STREAM : S_PAD_Q;
            S_PAD_Q:  if (w_q_zero) w_next = S_STREAM;
            S_STREAM: if (w_t_beat && w_t_zero) w_next = S_DRAIN;
            S_DRAIN:  if (w_t_zero) w_next = S_RESULT;
            S_RESULT: if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        arr_rst       = r_state == S_CLR;
        arr_S_load    = w_q_beat || r_state == S_PAD_Q;
        arr_S_valid   = w_q_beat;
        arr_S         = w_q_beat ? q_char : CH_A;
        arr_ripple_en = w_t_beat;
        arr_T         = w_t_beat ? t_char : CH_A;
    end

    assign arr_max_in  = '0;
    assign arr_V_in    = '0;
    assign arr_V_alpha = '0;
    assign arr_F_in    = '0;
    assign q_ready     = r_q_ready;
    assign t_ready     = r_t_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_score   = r_res_score;
    assign res_err     = r_res_err;
    assign cfg_err     = r_cfg_err;
endmodule
